// File: rtl/pdh_ctrl_seq.sv
// PS GPIO command sequencer: synchronizes toggle-strobed commands, holds a shadow/active config bank, commits atomically.
// Latency: response ack moves SYNC_STAGES+3 clk edges after the first edge that samples a new toggle.
// Backpressure: none on the wire; toggles arriving while busy are evaluated only after returning to IDLE. Optional: PDH_CTRL_STABLE_CHK_EN.
module pdh_ctrl_seq #(
    parameter int NUM_REGS    = 8,
    parameter int REG_WIDTH   = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [31:0]                   ps_cmd_i,
    output logic [31:0]                   ps_rsp_o,
    output logic [NUM_REGS*REG_WIDTH-1:0] cfg_o,
    output logic                          cfg_update_o,
    input  logic [REG_WIDTH-1:0]          status_i,
    output logic                          busy_o
);

    localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CNTW = $clog2(SYNC_STAGES + 1);
    localparam logic [4:0] NUM_REGS_L = 5'(NUM_REGS);
    localparam logic [4:0] STAT_ADDR  = 5'd31;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_READ   = 2'b10;
    localparam logic [1:0] OP_COMMIT = 2'b11;

    typedef enum logic [2:0] {INIT, IDLE, CAPTURE, EXEC, RESP} state_t;

    logic [31:0]          sync_q [SYNC_STAGES];
    logic [31:0]          synced;
    state_t               state_q, state_d;
    logic [CNTW-1:0]      init_cnt;
    logic                 init_done;
    logic                 acc_tog;
    logic                 pending;

    logic [1:0]           cap_op;
    logic [4:0]           cap_addr;
    logic [23:0]          cap_data;
    logic                 cap_bad;
    logic [IDXW-1:0]      idx;

    logic [REG_WIDTH-1:0] shadow_q [NUM_REGS];
    logic [REG_WIDTH-1:0] active_q [NUM_REGS];
    logic                 dirty_q;
    logic                 ex_err_q;
    logic [23:0]          ex_rdata_q;
    logic                 commit_q;

    logic                 ex_err;
    logic [23:0]          ex_rdata;
    logic                 do_write;
    logic                 do_commit;

`ifdef PDH_CTRL_STABLE_CHK_EN
    logic [30:0]          snap_q;
`endif

    assign synced    = sync_q[SYNC_STAGES-1];
    assign pending   = synced[31] ^ acc_tog;
    assign init_done = (init_cnt == CNTW'(SYNC_STAGES));
    assign busy_o    = (state_q != IDLE);
    assign idx       = cap_addr[IDXW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= ps_cmd_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= INIT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (init_done) state_d = IDLE;
            IDLE:    if (pending) state_d = CAPTURE;
            CAPTURE: state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    // INIT adopts whatever toggle level the PS left on the bus so reset release never fires a command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt <= '0;
            acc_tog  <= 1'b0;
            cap_op   <= OP_NOP;
            cap_addr <= '0;
            cap_data <= '0;
            cap_bad  <= 1'b0;
`ifdef PDH_CTRL_STABLE_CHK_EN
            snap_q   <= '0;
`endif
        end else begin
            case (state_q)
                INIT: begin
                    if (init_done) acc_tog <= synced[31];
                    else           init_cnt <= init_cnt + CNTW'(1);
                end
                IDLE: begin
`ifdef PDH_CTRL_STABLE_CHK_EN
                    if (pending) snap_q <= synced[30:0];
`endif
                end
                CAPTURE: begin
                    acc_tog  <= synced[31];
                    cap_addr <= synced[28:24];
                    cap_data <= synced[23:0];
`ifdef PDH_CTRL_STABLE_CHK_EN
                    if (synced[30:0] != snap_q) begin
                        cap_op  <= OP_NOP;
                        cap_bad <= 1'b1;
                    end else begin
                        cap_op  <= synced[30:29];
                        cap_bad <= 1'b0;
                    end
`else
                    cap_op  <= synced[30:29];
                    cap_bad <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ex_err    = 1'b0;
        ex_rdata  = '0;
        do_write  = 1'b0;
        do_commit = 1'b0;
        case (cap_op)
            OP_WRITE: begin
                if (cap_addr < NUM_REGS_L) do_write = 1'b1;
                else                       ex_err   = 1'b1;
            end
            OP_READ: begin
                if (cap_addr < NUM_REGS_L)
                    ex_rdata = cap_data[0] ? 24'(shadow_q[idx]) : 24'(active_q[idx]);
                else if (cap_addr == STAT_ADDR)
                    ex_rdata = 24'(status_i);
                else
                    ex_err = 1'b1;
            end
            OP_COMMIT: do_commit = 1'b1;
            default: ;
        endcase
        if (cap_bad) ex_err = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            dirty_q      <= 1'b0;
            ex_err_q     <= 1'b0;
            ex_rdata_q   <= '0;
            commit_q     <= 1'b0;
            ps_rsp_o     <= '0;
            cfg_update_o <= 1'b0;
        end else begin
            cfg_update_o <= 1'b0;
            if (state_q == EXEC) begin
                ex_err_q   <= ex_err;
                ex_rdata_q <= ex_rdata;
                commit_q   <= do_commit;
                if (do_write) begin
                    shadow_q[idx] <= REG_WIDTH'(cap_data);
                    dirty_q       <= 1'b1;
                end
                if (do_commit) begin
                    for (int i = 0; i < NUM_REGS; i++) active_q[i] <= shadow_q[i];
                    dirty_q <= 1'b0;
                end
            end
            if (state_q == RESP) begin
                ps_rsp_o     <= {acc_tog, ex_err_q, dirty_q, cap_addr, ex_rdata_q};
                cfg_update_o <= commit_q;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
        assign cfg_o[g*REG_WIDTH +: REG_WIDTH] = active_q[g];
    end

endmodule
